// File: rtl/inst_prefetch_queue_pkg.sv
// inst_prefetch_queue_pkg: shared constants and FSM encoding for the instruction prefetch queue
package inst_prefetch_queue_pkg;
  localparam logic [31:0] INST_NOP = 32'h0000_0033;
  typedef enum logic [1:0] {IDLE, REQ, DROP} pfq_state_t;
endpackage

// File: rtl/inst_prefetch_queue_fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of {pc, inst} pairs with push, pop, flush and occupancy count
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: sequential instruction prefetcher feeding the IF/ID register,
// with one outstanding memory request and flush-and-redirect on taken branches.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   if_ready,
  output logic                   if_valid,
  output logic [31:0]            if_inst,
  output logic [31:0]            if_pc,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] FULL = (AW+2)'(DEPTH);
  pfq_state_t state, state_nx;
  logic [31:0] fetch_pc, fetch_nx, drop_addr, drop_nx;
  logic [63:0] head;
  logic push, pop;
  logic [AW+1:0] occ_after;
  assign push      = state == REQ && imem_ack && !redirect_valid;
  assign pop       = if_valid && if_ready;
  assign occ_after = {1'b0, occupancy} + (AW+2)'(push) - (AW+2)'(pop);
  assign imem_req  = state != IDLE;
  // While dropping, the stale request keeps its original address; fetch_pc already holds the target.
  assign imem_addr = state == DROP ? drop_addr : fetch_pc;
  assign if_valid  = occupancy != '0;
  assign if_pc     = if_valid ? head[63:32] : '0;
  assign if_inst   = if_valid ? head[31:0] : INST_NOP;
  always_comb begin
    state_nx = state;
    fetch_nx = fetch_pc;
    drop_nx  = drop_addr;
    if (redirect_valid) begin
      state_nx = (state != IDLE && !imem_ack) ? DROP : REQ;
      fetch_nx = redirect_pc & ~32'h3;
      drop_nx  = state == REQ ? fetch_pc : drop_addr;
    end else if (state == IDLE) begin
      state_nx = {1'b0, occupancy} < FULL ? REQ : IDLE;
    end else if (imem_ack) begin
      fetch_nx = push ? fetch_pc + 32'd4 : fetch_pc;
      state_nx = (state == DROP || occ_after < FULL) ? REQ : IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      drop_addr <= '0;
    end else begin
      state     <= state_nx;
      fetch_pc  <= fetch_nx;
      drop_addr <= drop_nx;
    end
  fetch_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .push_data({fetch_pc, imem_rdata}),
    .head(head),
    .count(occupancy)
  );
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: directed scenarios plus a randomized run against a queue-level model
module tb_inst_prefetch_queue;
  localparam int DEPTH = 4;
  localparam int OW = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0033;
  logic clk = 0, rst = 0, redirect_valid = 0, imem_ack = 0, if_ready = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic imem_req, if_valid, req2, valid2;
  logic [31:0] imem_addr, if_inst, if_pc, addr2, inst2, pc2;
  logic [OW-1:0] occupancy, occ2;
  int checks = 0, errors = 0;
  logic [63:0] mq[$];
  logic [31:0] exp_pc, drop_pc;
  bit dropping;

  always #5 clk = ~clk;

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_ready(if_ready), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .occupancy(occupancy)
  );

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_ready(if_ready), .if_valid(valid2), .if_inst(inst2), .if_pc(pc2), .occupancy(occ2)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  task automatic model_clear();
    mq.delete();
    exp_pc = 32'h0;
    drop_pc = 32'h0;
    dropping = 0;
  endtask

  // Drive one cycle of inputs at a falling edge, advance the model, and stop at the next falling edge.
  task automatic step(input bit rdy, input bit ack, input bit redir, input logic [31:0] rpc);
    bit popd;
    if_ready = rdy;
    redirect_valid = redir;
    redirect_pc = rpc;
    imem_ack = ack && imem_req;
    imem_rdata = imem_ack ? mem_f(imem_addr) : 32'hDEAD_BEEF;
    popd = rdy && mq.size() != 0;
    if (redir) begin
      if (imem_req && !imem_ack && !dropping) drop_pc = exp_pc;
      dropping = imem_req && !imem_ack;
      mq.delete();
      exp_pc = rpc & ~32'h3;
    end else begin
      if (popd) void'(mq.pop_front());
      if (imem_ack && dropping) dropping = 0;
      else if (imem_ack) begin
        mq.push_back({exp_pc, mem_f(exp_pc)});
        exp_pc += 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 0;
    {redirect_valid, imem_ack, if_ready} = 3'b000;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({imem_req, if_valid, if_inst, if_pc, occupancy} !== {1'b0, 1'b0, NOP, 32'h0, {OW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_state got req=%b v=%b inst=%h pc=%h occ=%0d want 0 0 %h 0 0",
               imem_req, if_valid, if_inst, if_pc, occupancy, NOP);
    end
    rst = 1;
  endtask

  task automatic test_zero_wait();
    do_reset();
    step(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'(4 * i)}) begin
        errors++;
        $display("FAIL zw_addr[%0d] got req=%b addr=%h want 1 %h", i, imem_req, imem_addr, 32'(4 * i));
      end
      if (i > 0) begin
        checks++;
        if ({if_valid, if_pc, if_inst, occupancy} !== {1'b1, 32'(4 * (i - 1)), mem_f(32'(4 * (i - 1))), OW'(1)}) begin
          errors++;
          $display("FAIL zw_head[%0d] got v=%b pc=%h inst=%h occ=%0d want 1 %h %h 1",
                   i, if_valid, if_pc, if_inst, occupancy, 32'(4 * (i - 1)), mem_f(32'(4 * (i - 1))));
        end
      end
      step(1, 1, 0, 0);
    end
  endtask

  task automatic test_full();
    int n = 0;
    do_reset();
    step(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (imem_req) n++;
      step(0, 1, 0, 0);
    end
    checks++;
    if (n !== 4 || {imem_req, occupancy, if_pc} !== {1'b0, OW'(DEPTH), 32'h0}) begin
      errors++;
      $display("FAIL full_stop got reqs=%0d req=%b occ=%0d pc=%h want 4 0 %0d 0", n, imem_req, occupancy, if_pc, DEPTH);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({if_valid, if_pc} !== {1'b1, 32'(4 * k)}) begin
        errors++;
        $display("FAIL full_drain[%0d] got v=%b pc=%h want 1 %h", k, if_valid, if_pc, 32'(4 * k));
      end
      step(1, 1, 0, 0);
    end
    checks++;
    if ({if_valid, if_pc} !== {1'b1, 32'h10}) begin
      errors++;
      $display("FAIL full_resume got v=%b pc=%h want 1 00000010", if_valid, if_pc);
    end
  endtask

  task automatic test_delayed_ack();
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({imem_req, imem_addr, if_valid, if_inst, if_pc} !== {1'b1, 32'h0, 1'b0, NOP, 32'h0}) begin
        errors++;
        $display("FAIL delay_hold[%0d] got req=%b addr=%h v=%b inst=%h pc=%h want 1 0 0 %h 0",
                 i, imem_req, imem_addr, if_valid, if_inst, if_pc, NOP);
      end
      step(1, 0, 0, 0);
    end
    step(1, 1, 0, 0);
    checks++;
    if ({if_valid, if_pc, if_inst, imem_addr} !== {1'b1, 32'h0, mem_f(32'h0), 32'h4}) begin
      errors++;
      $display("FAIL delay_done got v=%b pc=%h inst=%h addr=%h want 1 0 %h 4", if_valid, if_pc, if_inst, imem_addr, mem_f(32'h0));
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 1, 32'h103);
    checks++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL drop_hold got req=%b addr=%h v=%b want 1 0 0", imem_req, imem_addr, if_valid);
    end
    step(1, 1, 0, 0);
    checks++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h100, 1'b0}) begin
      errors++;
      $display("FAIL drop_reissue got req=%b addr=%h v=%b want 1 100 0", imem_req, imem_addr, if_valid);
    end
    step(1, 1, 0, 0);
    checks++;
    if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h100, mem_f(32'h100)}) begin
      errors++;
      $display("FAIL drop_head got v=%b pc=%h inst=%h want 1 100 %h", if_valid, if_pc, if_inst, mem_f(32'h100));
    end
  endtask

  task automatic test_redirect_ack_pop();
    do_reset();
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if ({occupancy, imem_req} !== {OW'(2), 1'b1}) begin
      errors++;
      $display("FAIL rap_setup got occ=%0d req=%b want 2 1", occupancy, imem_req);
    end
    step(1, 1, 1, 32'h200);
    checks++;
    if ({occupancy, if_valid, imem_req, imem_addr} !== {OW'(0), 1'b0, 1'b1, 32'h200}) begin
      errors++;
      $display("FAIL rap_flush got occ=%0d v=%b req=%b addr=%h want 0 0 1 200", occupancy, if_valid, imem_req, imem_addr);
    end
    step(1, 1, 0, 0);
    checks++;
    if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h200, mem_f(32'h200)}) begin
      errors++;
      $display("FAIL rap_head got v=%b pc=%h inst=%h want 1 200 %h", if_valid, if_pc, if_inst, mem_f(32'h200));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({req2, addr2} !== {1'b1, 32'hFFFF_FFF8 + 32'(4 * i)}) begin
        errors++;
        $display("FAIL wrap_addr[%0d] got req=%b addr=%h want 1 %h", i, req2, addr2, 32'hFFFF_FFF8 + 32'(4 * i));
      end
      step(1, 1, 0, 0);
    end
    checks++;
    if ({valid2, pc2} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL wrap_head got v=%b pc=%h want 1 0", valid2, pc2);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 0, 0, 0);
    #2 rst = 0;
    #1;
    checks++;
    if ({imem_req, req2, occupancy} !== {1'b0, 1'b0, {OW{1'b0}}}) begin
      errors++;
      $display("FAIL async_rst got req=%b req2=%b occ=%0d want 0 0 0", imem_req, req2, occupancy);
    end
    imem_ack = 1;
    imem_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({imem_req, if_valid, occupancy} !== {1'b0, 1'b0, {OW{1'b0}}}) begin
      errors++;
      $display("FAIL async_ack_ignored got req=%b v=%b occ=%0d want 0 0 0", imem_req, if_valid, occupancy);
    end
    imem_ack = 0;
    model_clear();
    rst = 1;
  endtask

  task automatic test_random();
    int idle_run = 0;
    logic [31:0] want_addr;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      checks++;
      if (if_valid !== (mq.size() != 0) || occupancy !== OW'(mq.size())) begin
        errors++;
        $display("FAIL rnd_occ[%0d] got v=%b occ=%0d want %b %0d", c, if_valid, occupancy, mq.size() != 0, mq.size());
      end
      checks++;
      if (mq.size() != 0 ? ({if_pc, if_inst} !== mq[0]) : ({if_pc, if_inst} !== {32'h0, NOP})) begin
        errors++;
        $display("FAIL rnd_head[%0d] got pc=%h inst=%h want %h", c, if_pc, if_inst, mq.size() != 0 ? mq[0] : {32'h0, NOP});
      end
      if (imem_req) begin
        want_addr = dropping ? drop_pc : exp_pc;
        checks++;
        if (imem_addr !== want_addr) begin
          errors++;
          $display("FAIL rnd_addr[%0d] got %h want %h", c, imem_addr, want_addr);
        end
        checks++;
        if (!dropping && mq.size() >= DEPTH) begin
          errors++;
          $display("FAIL rnd_gate[%0d] got req with occ=%0d want occ<%0d", c, mq.size(), DEPTH);
        end
      end
      idle_run = (!imem_req && mq.size() < DEPTH) ? idle_run + 1 : 0;
      checks++;
      if (idle_run > 1) begin
        errors++;
        $display("FAIL rnd_starve[%0d] got %0d idle cycles with space want <=1", c, idle_run);
      end
      step($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 6, $urandom_range(15, 0) == 0, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_full();
    test_delayed_ack();
    test_redirect_drop();
    test_redirect_ack_pop();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
